call_scheduler: RTL

CALL_SCHEDULER -- requirements
Module: call_scheduler

---
 rtl/call_scheduler_if.sv | 27 ++
 rtl/call_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/call_scheduler_if.sv
// Call-button, car-position and scheduler-output bundle for call_scheduler.
// The master side is the car controller / panel; the slave side is the scheduler.
interface call_scheduler_if;
  logic       btn1;
  logic       btn2;
  logic       btn3;
  logic [1:0] floor;
  logic       arrived;
  logic       sos_mode;
  logic       weight_limit_exceeded;
  logic       led1;
  logic       led2;
  logic       led3;
  logic [1:0] goal_floor;
  logic       goal_valid;
  logic [1:0] dir;

  modport master (
    output btn1, btn2, btn3, floor, arrived, sos_mode, weight_limit_exceeded,
    input  led1, led2, led3, goal_floor, goal_valid, dir
  );

  modport slave (
    input  btn1, btn2, btn3, floor, arrived, sos_mode, weight_limit_exceeded,
    output led1, led2, led3, goal_floor, goal_valid, dir
  );
endinterface

// File: rtl/call_scheduler.sv
// Three-floor elevator call scheduler: button qualification, request latching, direction FSM, goal selection.
// Optional macro CALL_DEBOUNCE_EN adds per-button saturating debounce counters.
module call_scheduler #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [1:0] labelF1         = 2'b00,
  parameter logic [1:0] labelF2         = 2'b01,
  parameter logic [1:0] labelF3         = 2'b10
) (
  input logic              clk,
  input logic              button_reset,
  call_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } dir_t;

  localparam logic [1:0] LABELS [3] = '{labelF1, labelF2, labelF3};

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
    $error("call_scheduler: DEBOUNCE_CYCLES must be in 1..15");
  end

  logic [2:0] raw_btn;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] press;
  logic [1:0] cur_floor;
  logic [2:0] led;
  logic [2:0] led_next;
  dir_t       state;
  dir_t       next_state;
  logic [1:0] goal_q;
  logic [1:0] goal_next;
  logic       valid_q;
  logic       valid_next;
  logic       up_found;
  logic       down_found;
  logic [1:0] up_goal;
  logic [1:0] down_goal;

  assign raw_btn   = {bus.btn3, bus.btn2, bus.btn1};
  assign cur_floor = (bus.floor == 2'b11) ? labelF1 : bus.floor;

  always_ff @(posedge clk or posedge button_reset) begin
    if (button_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_btn;
      sync2 <= sync1;
    end
  end

`ifdef CALL_DEBOUNCE_EN
  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_CYCLES);

  logic [3:0] cnt [3];
  logic [2:0] press_q;

  // press_q fires once, on the edge the counter steps into saturation
  always_ff @(posedge clk or posedge button_reset) begin
    if (button_reset) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      press_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!sync2[i]) begin
          cnt[i]     <= '0;
          press_q[i] <= 1'b0;
        end else begin
          if (cnt[i] != DEB_MAX) cnt[i] <= cnt[i] + 4'd1;
          press_q[i] <= (cnt[i] == DEB_MAX - 4'd1);
        end
      end
    end
  end

  assign press = press_q;
`else
  logic [2:0] sync_prev;

  always_ff @(posedge clk or posedge button_reset) begin
    if (button_reset) sync_prev <= '0;
    else              sync_prev <= sync2;
  end

  assign press = sync2 & ~sync_prev;
`endif

  // Request latching; a clear from arrived overrides a same-cycle set
  always_comb begin
    led_next = led;
    if (bus.sos_mode) begin
      led_next = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (press[i] && !(LABELS[i] == cur_floor && state == IDLE)) led_next[i] = 1'b1;
        if (bus.arrived && LABELS[i] == cur_floor) led_next[i] = 1'b0;
      end
    end
  end

  always_comb begin
    up_found   = 1'b0;
    down_found = 1'b0;
    up_goal    = cur_floor;
    down_goal  = cur_floor;
    for (int i = 0; i < 3; i++) begin
      if (led[i] && LABELS[i] > cur_floor && (!up_found || LABELS[i] < up_goal)) begin
        up_found = 1'b1;
        up_goal  = LABELS[i];
      end
      if (led[i] && LABELS[i] < cur_floor && (!down_found || LABELS[i] > down_goal)) begin
        down_found = 1'b1;
        down_goal  = LABELS[i];
      end
    end
  end

  always_ff @(posedge clk or posedge button_reset) begin
    if (button_reset) begin
      led     <= '0;
      state   <= IDLE;
      goal_q  <= labelF1;
      valid_q <= 1'b0;
    end else begin
      led     <= led_next;
      state   <= next_state;
      goal_q  <= goal_next;
      valid_q <= valid_next;
    end
  end

  // Goal follows the registered direction, so it trails dir by one edge
  always_comb begin
    next_state = state;
    goal_next  = goal_q;
    valid_next = 1'b0;
    if (bus.sos_mode) begin
      next_state = IDLE;
      goal_next  = cur_floor;
    end else if (!bus.weight_limit_exceeded) begin
      case (state)
        UP:      next_state = up_found ? UP : (down_found ? DOWN : IDLE);
        DOWN:    next_state = down_found ? DOWN : (up_found ? UP : IDLE);
        default: next_state = up_found ? UP : (down_found ? DOWN : IDLE);
      endcase
      case (state)
        UP: begin
          goal_next  = up_goal;
          valid_next = up_found;
        end
        DOWN: begin
          goal_next  = down_goal;
          valid_next = down_found;
        end
        default: goal_next = cur_floor;
      endcase
    end
  end

  assign bus.led1       = led[0];
  assign bus.led2       = led[1];
  assign bus.led3       = led[2];
  assign bus.dir        = state;
  assign bus.goal_floor = goal_q;
  assign bus.goal_valid = valid_q;

endmodule
